// File: rtl/cafe_pkg.sv
// -----------------------------------------------------------------------------
// cafe_pkg
// Shared types and default timing for the drink dispense sequencer.
//   drink_t      2-bit drink code as delivered by the selection FSM
//   seq_state_t  sequencer phase encoding
//   act_t        bundle of the state-decoded (Moore) outputs
//   decode_out   maps a phase to its actuator/status pattern
//   is_phase     true for the timed phases (AGUA/CAFE/LECHE)
// -----------------------------------------------------------------------------
package cafe_pkg;

  typedef enum logic [1:0] {
    NINGUNO        = 2'b00,
    CAFE_SOLO      = 2'b01,
    CAFE_SIN_LECHE = 2'b10,
    CAFE_LECHE     = 2'b11
  } drink_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AGUA  = 3'd1,
    S_CAFE  = 3'd2,
    S_LECHE = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  localparam logic [15:0] DEF_CLK_DIV = 16'd50000;
  localparam logic [7:0]  DEF_T_AGUA  = 8'd30;
  localparam logic [7:0]  DEF_T_CAFE  = 8'd20;
  localparam logic [7:0]  DEF_T_LECHE = 8'd15;

  typedef struct packed {
    logic bomba;
    logic cafe;
    logic leche;
    logic busy;
    logic done;
  } act_t;

  // Moore output pattern for a given phase.
  function automatic act_t decode_out(input seq_state_t s);
    act_t a;
    a = '0;
    case (s)
      S_AGUA: begin
        a.bomba = 1'b1;
        a.busy  = 1'b1;
      end
      S_CAFE: begin
        a.cafe = 1'b1;
        a.busy = 1'b1;
      end
      S_LECHE: begin
        a.leche = 1'b1;
        a.busy  = 1'b1;
      end
      S_DONE: begin
        a.done = 1'b1;
      end
      default: begin
        a = '0;
      end
    endcase
    return a;
  endfunction

  // Timed phases are the ones that own the phase timer.
  function automatic logic is_phase(input seq_state_t s);
    return (s == S_AGUA) || (s == S_CAFE) || (s == S_LECHE);
  endfunction

endpackage

// File: rtl/cafe_dispense_seq_if.sv
// -----------------------------------------------------------------------------
// cafe_dispense_seq_if
// Panel-side bundle of the dispense sequencer.
//   M1, M0        drink code from the selection FSM
//   start, abort  user requests (level)
//   bomba_agua, valvula_cafe, valvula_leche   actuator enables
//   busy, done, sin_leche, err                status to the panel
// master: panel/selection side (drives requests, reads status)
// slave : sequencer side
// -----------------------------------------------------------------------------
interface cafe_dispense_seq_if;
  logic M1;
  logic M0;
  logic start;
  logic abort;
  logic bomba_agua;
  logic valvula_cafe;
  logic valvula_leche;
  logic busy;
  logic done;
  logic sin_leche;
  logic err;

  modport master (
    output M1, M0, start, abort,
    input  bomba_agua, valvula_cafe, valvula_leche, busy, done, sin_leche, err
  );

  modport slave (
    input  M1, M0, start, abort,
    output bomba_agua, valvula_cafe, valvula_leche, busy, done, sin_leche, err
  );
endinterface

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Measures one phase of len*CLK_DIV clock cycles.
//   clk     system clock
//   r       synchronous reset, active-low
//   load    high in the first cycle of a phase; restarts the count
//   len     phase length in ticks (>=1), sampled while load is high
//   expire  high in the last cycle of the phase
// The load cycle itself counts as the first cycle of the phase: the count is
// evaluated on the "effective" values (reload values when load is high), so
// no residue from a previous phase can leak in.
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter logic [15:0] CLK_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       r,
  input  logic       load,
  input  logic [7:0] len,
  output logic       expire
);

  localparam int            PW         = $clog2(32'(CLK_DIV) + 32'd1);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(CLK_DIV);
  localparam logic [PW-1:0] PRE_ONE    = PW'(32'd1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [PW-1:0] pre_eff_s;
  logic [7:0]    tick_q;
  logic [7:0]    tick_d;
  logic [7:0]    tick_eff_s;

  // Effective counts for this cycle, expiry and next-count computation.
  always_comb begin
    pre_eff_s  = pre_q;
    tick_eff_s = tick_q;
    if (load) begin
      pre_eff_s  = PRE_RELOAD;
      tick_eff_s = len;
    end else begin
      pre_eff_s  = pre_q;
      tick_eff_s = tick_q;
    end

    expire = (pre_eff_s == PRE_ONE) && (tick_eff_s == 8'd1);

    pre_d  = pre_eff_s;
    tick_d = tick_eff_s;
    if (pre_eff_s == PRE_ONE) begin
      pre_d = PRE_RELOAD;
      // Saturate at zero so idle running never wraps the tick counter.
      if (tick_eff_s != 8'd0) begin
        tick_d = tick_eff_s - 8'd1;
      end else begin
        tick_d = 8'd0;
      end
    end else begin
      pre_d  = pre_eff_s - PRE_ONE;
      tick_d = tick_eff_s;
    end
  end

  // Prescaler and tick counter registers.
  always_ff @(posedge clk) begin
    if (!r) begin
      pre_q  <= PRE_RELOAD;
      tick_q <= 8'd0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/cafe_dispense_seq.sv
// -----------------------------------------------------------------------------
// cafe_dispense_seq
// Sequences water pump, coffee valve and milk valve for the drink chosen
// upstream, then reports completion.
//   clk   system clock, rising edge
//   r     synchronous reset, active-low
//   bus   cafe_dispense_seq_if.slave: M1/M0/start/abort in; actuators,
//         busy, done, sin_leche and err out (all registered)
// Phase flow: IDLE -> AGUA -> CAFE -> [LECHE if code 11] -> DONE -> IDLE.
// The drink code is captured at start; later code changes are ignored.
// -----------------------------------------------------------------------------
module cafe_dispense_seq
  import cafe_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = DEF_CLK_DIV,
  parameter logic [7:0]  T_AGUA  = DEF_T_AGUA,
  parameter logic [7:0]  T_CAFE  = DEF_T_CAFE,
  parameter logic [7:0]  T_LECHE = DEF_T_LECHE
) (
  input  logic              clk,
  input  logic              r,
  cafe_dispense_seq_if.slave bus
);

  seq_state_t state_q;
  drink_t     code_q;
  logic       sin_leche_q;
  logic       err_q;
  logic       entry_q;
  act_t       out_q;

  drink_t     code_s;
  logic [7:0] len_s;
  logic       expire_s;

  assign code_s = drink_t'({bus.M1, bus.M0});

  // Phase length for the timer, chosen by the phase currently running.
  always_comb begin
    len_s = 8'd1;
    case (state_q)
      S_AGUA:  len_s = T_AGUA;
      S_CAFE:  len_s = T_CAFE;
      S_LECHE: len_s = T_LECHE;
      default: len_s = 8'd1;
    endcase
  end

  // entry_q is high in the first cycle of every timed phase, so the timer
  // restarts exactly on phase entry.
  phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (clk),
    .r      (r),
    .load   (entry_q),
    .len    (len_s),
    .expire (expire_s)
  );

  // Sequencer FSM with registered Moore outputs; each transition also loads
  // the output pattern of the destination state.
  always_ff @(posedge clk) begin
    if (!r) begin
      state_q     <= S_IDLE;
      code_q      <= NINGUNO;
      sin_leche_q <= 1'b0;
      err_q       <= 1'b0;
      entry_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      entry_q <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= decode_out(state_q);
      case (state_q)
        S_IDLE: begin
          if (bus.start && (code_s != NINGUNO)) begin
            code_q      <= code_s;
            sin_leche_q <= (code_s == CAFE_SIN_LECHE);
            state_q     <= S_AGUA;
            out_q       <= decode_out(S_AGUA);
            entry_q     <= 1'b1;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_AGUA: begin
          // abort wins over expiry in the same cycle.
          if (bus.abort) begin
            state_q <= S_IDLE;
            out_q   <= decode_out(S_IDLE);
          end else if (expire_s) begin
            state_q <= S_CAFE;
            out_q   <= decode_out(S_CAFE);
            entry_q <= 1'b1;
          end else begin
            state_q <= S_AGUA;
          end
        end
        S_CAFE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            out_q   <= decode_out(S_IDLE);
          end else if (expire_s && (code_q == CAFE_LECHE)) begin
            state_q <= S_LECHE;
            out_q   <= decode_out(S_LECHE);
            entry_q <= 1'b1;
          end else if (expire_s) begin
            state_q <= S_DONE;
            out_q   <= decode_out(S_DONE);
          end else begin
            state_q <= S_CAFE;
          end
        end
        S_LECHE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            out_q   <= decode_out(S_IDLE);
          end else if (expire_s) begin
            state_q <= S_DONE;
            out_q   <= decode_out(S_DONE);
          end else begin
            state_q <= S_LECHE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          out_q   <= decode_out(S_IDLE);
        end
        default: begin
          state_q <= S_IDLE;
          out_q   <= decode_out(S_IDLE);
        end
      endcase
    end
  end

  assign bus.bomba_agua    = out_q.bomba;
  assign bus.valvula_cafe  = out_q.cafe;
  assign bus.valvula_leche = out_q.leche;
  assign bus.busy          = out_q.busy;
  assign bus.done          = out_q.done;
  assign bus.sin_leche     = sin_leche_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_cafe_dispense_seq.sv
// -----------------------------------------------------------------------------
// tb_cafe_dispense_seq
// Self-checking bench for cafe_dispense_seq with CLK_DIV=4, T_AGUA=3,
// T_CAFE=2, T_LECHE=2 (water 12, coffee 8, milk 8 cycles).
// -----------------------------------------------------------------------------
module tb_cafe_dispense_seq;

  logic clk;
  logic r;
  int   n_tests;
  int   n_fail;

  cafe_dispense_seq_if bus ();

  cafe_dispense_seq #(
    .CLK_DIV (16'd4),
    .T_AGUA  (8'd3),
    .T_CAFE  (8'd2),
    .T_LECHE (8'd2)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    int         n_agua;
    int         n_cafe;
    int         n_leche;
    int         n_busy;
    int         n_done;
    int         n_err;
    int         sin;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " bomba_agua"},    int'(bus.bomba_agua),    0);
    check({tag, " valvula_cafe"},  int'(bus.valvula_cafe),  0);
    check({tag, " valvula_leche"}, int'(bus.valvula_leche), 0);
    check({tag, " busy"},          int'(bus.busy),          0);
    check({tag, " done"},          int'(bus.done),          0);
  endtask

  // Pulse start for one cycle with the given code, then count each output
  // over a 40-cycle window starting with the first post-start cycle.
  task automatic run_brew(input vec_t v, input string tag);
    int na, nc, nl, nb, nd, ne, bad;
    na = 0; nc = 0; nl = 0; nb = 0; nd = 0; ne = 0; bad = 0;
    @(negedge clk);
    bus.M1    = v.code[1];
    bus.M0    = v.code[0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.bomba_agua)    na++;
      if (bus.valvula_cafe)  nc++;
      if (bus.valvula_leche) nl++;
      if (bus.busy)          nb++;
      if (bus.done)          nd++;
      if (bus.err)           ne++;
      if ((int'(bus.bomba_agua) + int'(bus.valvula_cafe) + int'(bus.valvula_leche))
          != int'(bus.busy))
        bad++;
      @(negedge clk);
    end
    check({tag, " agua cycles"},  na, v.n_agua);
    check({tag, " cafe cycles"},  nc, v.n_cafe);
    check({tag, " leche cycles"}, nl, v.n_leche);
    check({tag, " busy cycles"},  nb, v.n_busy);
    check({tag, " done cycles"},  nd, v.n_done);
    check({tag, " err cycles"},   ne, v.n_err);
    check({tag, " actuator/busy overlap"}, bad, 0);
    check({tag, " sin_leche"},    int'(bus.sin_leche), v.sin);
  endtask

  initial begin
    int nd, nact;
    n_tests   = 0;
    n_fail    = 0;
    r         = 1'b0;
    bus.M1    = 1'b0;
    bus.M0    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // code, agua, cafe, leche, busy, done, err, sin_leche
    tbl[0] = '{2'b01, 12, 8, 0, 20, 1, 0, 0};
    tbl[1] = '{2'b11, 12, 8, 8, 28, 1, 0, 0};
    tbl[2] = '{2'b10, 12, 8, 0, 20, 1, 0, 1};
    tbl[3] = '{2'b01, 12, 8, 0, 20, 1, 0, 0};
    tbl[4] = '{2'b00,  0, 0, 0,  0, 0, 1, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset err",       int'(bus.err),       0);
    check("reset sin_leche", int'(bus.sin_leche), 0);
    r = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_brew(tbl[t], $sformatf("vec%0d", t));
    end

    // Code 11; code flip plus start mid-AGUA ignored; abort at CAFE cycle 3.
    @(negedge clk);
    bus.M1 = 1'b1; bus.M0 = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        check("abort_seq agua after restart", int'(bus.bomba_agua), 1);
        check("abort_seq no err mid-brew",    int'(bus.err),        0);
        bus.start = 1'b0;
      end
      if (k == 4) begin
        bus.M1 = 1'b0; bus.M0 = 1'b0; bus.start = 1'b1;
      end
      if (k == 15) begin
        check("abort_seq cafe at k15", int'(bus.valvula_cafe), 1);
        bus.abort = 1'b1;
      end
      @(negedge clk);
    end
    check_idle_outputs("abort_seq after abort");
    bus.abort = 1'b0;
    nd = 0; nact = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) nd++;
      if (bus.bomba_agua || bus.valvula_cafe || bus.valvula_leche) nact++;
      @(negedge clk);
    end
    check("abort_seq no done",      nd,   0);
    check("abort_seq no actuators", nact, 0);

    // Code 11, reset during LECHE, then a clean code 01 brew.
    bus.M1 = 1'b1; bus.M0 = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      if (k == 22) begin
        check("rst_seq leche at k22", int'(bus.valvula_leche), 1);
        r = 1'b0;
      end
      @(negedge clk);
    end
    check_idle_outputs("rst_seq after reset");
    r = 1'b1;
    run_brew(tbl[0], "rst_seq rebrew");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
